regfile_sb: RTL and testbench

Parametrised general-purpose register file with N read ports, 1–2 write ports, a pending-write scoreboard and a post-reset clear sweep. It sits between decode (reads, issue marking) and writeback (writes). Hazard stalls are detected here and exported as one flag, so the pipeline needs no separate stall-counting logic. Register 0 is hard-wired to zero and is never busy.

---
 rtl/regfile_sb.sv | 116 +++++++++++
 tb/tb_regfile_sb.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// Register file with pending-write scoreboard, post-reset clear sweep and hazard stall flag.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREAD  = 2,
  parameter int NWRITE = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     init_done,
  input  logic                     flush,
  input  logic                     iss_valid,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic [NWRITE-1:0]        wr_en,
  input  logic [NWRITE*ADDR_W-1:0] wr_addr,
  input  logic [NWRITE*DATA_W-1:0] wr_data,
  input  logic [NREAD-1:0]         rd_en,
  input  logic [NREAD*ADDR_W-1:0]  rd_addr,
  output logic [NREAD*DATA_W-1:0]  rd_data,
  output logic [NREAD-1:0]         rd_busy,
  output logic                     rd_stall
);

  localparam int NREG = 1 << ADDR_W;

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t              r_state, w_state_next;
  logic [ADDR_W-1:0]   r_ptr, w_ptr_next;
  logic [DATA_W-1:0]   r_mem [NREG];
  logic [NREG-1:0]     r_busy, w_busy_next;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_INIT;
      r_ptr   <= ADDR_W'(1);
      r_busy  <= '0;
    end else begin
      r_state <= w_state_next;
      r_ptr   <= w_ptr_next;
      r_busy  <= w_busy_next;
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    w_ptr_next   = r_ptr;
    if (r_state == S_INIT) begin
      w_ptr_next = r_ptr + ADDR_W'(1);
      if (r_ptr == {ADDR_W{1'b1}}) w_state_next = S_RUN;
    end
  end

  assign init_done = (r_state == S_RUN);

  // Scoreboard: writes retire, issue re-marks (so issue wins a same-cycle tie), flush wipes all.
  always_comb begin
    w_busy_next = r_busy;
    if (r_state == S_RUN) begin
      for (int w = 0; w < NWRITE; w++) begin
        if (wr_en[w] && wr_addr[w*ADDR_W +: ADDR_W] != '0)
          w_busy_next[wr_addr[w*ADDR_W +: ADDR_W]] = 1'b0;
      end
      if (iss_valid && iss_addr != '0) w_busy_next[iss_addr] = 1'b1;
      if (flush) w_busy_next = '0;
    end
  end

  // NOTE: the array has no reset; the INIT sweep zeroes it instead, keeping it RAM-friendly.
  always_ff @(posedge clk) begin
    if (r_state == S_INIT) begin
      r_mem[r_ptr] <= '0;
    end else begin
      for (int w = 0; w < NWRITE; w++) begin
        if (wr_en[w] && wr_addr[w*ADDR_W +: ADDR_W] != '0)
          r_mem[wr_addr[w*ADDR_W +: ADDR_W]] <= wr_data[w*DATA_W +: DATA_W];
      end
    end
  end

  for (genvar gp = 0; gp < NREAD; gp++) begin : g_rd
    logic [ADDR_W-1:0] w_a;
    logic [DATA_W-1:0] w_d;
    logic              w_b;

    assign w_a = rd_addr[gp*ADDR_W +: ADDR_W];

    always_comb begin
      w_d = '0;
      w_b = 1'b0;
      if (init_done && rd_en[gp] && w_a != '0) begin
        w_d = r_mem[w_a];
        w_b = r_busy[w_a];
`ifdef REGFILE_BYPASS_EN
        // Later ports override earlier ones, giving port 1 priority.
        for (int w = 0; w < NWRITE; w++) begin
          if (wr_en[w] && wr_addr[w*ADDR_W +: ADDR_W] == w_a) begin
            w_d = wr_data[w*DATA_W +: DATA_W];
            w_b = iss_valid && (iss_addr == w_a) && !flush;
          end
        end
`else
`endif
      end
    end

    assign rd_data[gp*DATA_W +: DATA_W] = w_d;
    assign rd_busy[gp]                  = w_b;
  end

  assign rd_stall = !init_done || (|rd_busy);

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb (NREAD=2, NWRITE=2): directed scenarios plus a random run
// compared against a behavioural register/scoreboard model.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic        init_done;
  logic        flush;
  logic        iss_valid;
  logic [4:0]  iss_addr;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        rd_stall;

  int n_pass = 0;
  int n_total = 0;

  regfile_sb #(.DATA_W(32), .ADDR_W(5), .NREAD(2), .NWRITE(2)) dut (
    .clk(clk), .rst(rst), .init_done(init_done), .flush(flush),
    .iss_valid(iss_valid), .iss_addr(iss_addr),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .rd_stall(rd_stall)
  );

  always #5 clk = ~clk;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  // Behavioural model: architectural register values, pending flags, and sweep progress.
  logic [31:0] m_mem [32];
  bit          m_busy [32];
  int          m_cnt;
  bit          m_run;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_cnt = 0;
      m_run = 1'b0;
      for (int r = 0; r < 32; r++) begin
        m_mem[r]  = '0;
        m_busy[r] = 1'b0;
      end
    end else if (!m_run) begin
      m_cnt++;
      if (m_cnt == 31) m_run = 1'b1;
    end else begin
      for (int w = 0; w < 2; w++)
        if (wr_en[w] && wr_addr[w*5 +: 5] != 0) m_mem[wr_addr[w*5 +: 5]] = wr_data[w*32 +: 32];
      if (flush) begin
        for (int r = 0; r < 32; r++) m_busy[r] = 1'b0;
      end else begin
        for (int w = 0; w < 2; w++)
          if (wr_en[w]) m_busy[wr_addr[w*5 +: 5]] = 1'b0;
        if (iss_valid && iss_addr != 0) m_busy[iss_addr] = 1'b1;
      end
    end
  end

  function automatic void exp_read(input int p, output logic [31:0] d, output logic b);
    logic [4:0] a;
    a = rd_addr[p*5 +: 5];
    d = '0;
    b = 1'b0;
    if (m_run && rd_en[p] && a != 0) begin
      d = m_mem[a];
      b = m_busy[a];
      if (BYPASS) begin
        if (wr_en[1] && wr_addr[9:5] == a) begin
          d = wr_data[63:32];
          b = iss_valid && iss_addr == a && !flush;
        end else if (wr_en[0] && wr_addr[4:0] == a) begin
          d = wr_data[31:0];
          b = iss_valid && iss_addr == a && !flush;
        end
      end
    end
  endfunction

  task automatic idle();
    flush = 0; iss_valid = 0; iss_addr = 0;
    wr_en = 0; wr_addr = 0; wr_data = 0;
    rd_en = 0; rd_addr = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_init(input string name);
    int k;
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (init_done) begin
        k = i;
        break;
      end
    end
    n_total++;
    if (k !== 31) $display("FAIL %s: init_done rose after %0d edges, expected 31", name, k);
    else n_pass++;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b0;
    rd_en = 2'b11; rd_addr = {5'd6, 5'd5};
    repeat (3) tick();
    #1;
    n_total++;
    if ({init_done, rd_busy, rd_stall} !== 4'b0001)
      $display("FAIL reset_flags: got {done,busy,stall}=%b expected 0001", {init_done, rd_busy, rd_stall});
    else n_pass++;
    n_total++;
    if (rd_data !== 64'd0) $display("FAIL reset_data: got %h expected 0", rd_data);
    else n_pass++;
  endtask

  task automatic test_init_ignore();
    // Writes and issues held throughout the sweep must leave no trace.
    rst = 1'b1;
    wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'd0, 32'h11};
    iss_valid = 1; iss_addr = 5'd5;
    #1;
    n_total++;
    if (rd_stall !== 1'b1) $display("FAIL init_stall: got %b expected 1", rd_stall);
    else n_pass++;
    wait_init("init_time");
    idle();
    rd_en = 2'b01; rd_addr = {5'd0, 5'd5};
    #1;
    n_total++;
    if ({rd_data[31:0], rd_busy[0], rd_stall} !== {32'd0, 1'b0, 1'b0})
      $display("FAIL init_ignore: got data=%h busy=%b stall=%b expected 0/0/0", rd_data[31:0], rd_busy[0], rd_stall);
    else n_pass++;
  endtask

  task automatic test_issue_hazard();
    idle();
    iss_valid = 1; iss_addr = 5'd3;
    tick();
    idle();
    rd_en = 2'b01; rd_addr = {5'd0, 5'd3};
    #1;
    n_total++;
    if ({rd_busy[0], rd_stall} !== 2'b11)
      $display("FAIL issue_busy: got busy=%b stall=%b expected 1/1", rd_busy[0], rd_stall);
    else n_pass++;
    wr_en = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = {32'd0, 32'hDEADBEEF};
    #1;
    n_total++;
    if (BYPASS) begin
      if ({rd_data[31:0], rd_busy[0], rd_stall} !== {32'hDEADBEEF, 2'b00})
        $display("FAIL bypass_hit: got data=%h busy=%b stall=%b expected deadbeef/0/0", rd_data[31:0], rd_busy[0], rd_stall);
      else n_pass++;
    end else begin
      if ({rd_busy[0], rd_stall} !== 2'b11)
        $display("FAIL nobypass_stall: got busy=%b stall=%b expected 1/1", rd_busy[0], rd_stall);
      else n_pass++;
    end
    tick();
    wr_en = 2'b00;
    #1;
    n_total++;
    if ({rd_data[31:0], rd_busy[0], rd_stall} !== {32'hDEADBEEF, 2'b00})
      $display("FAIL writeback_read: got data=%h busy=%b stall=%b expected deadbeef/0/0", rd_data[31:0], rd_busy[0], rd_stall);
    else n_pass++;
  endtask

  task automatic test_dual_write();
    idle();
    wr_en = 2'b11; wr_addr = {5'd7, 5'd7}; wr_data = {32'hB, 32'hA};
    tick();
    idle();
    rd_en = 2'b10; rd_addr = {5'd7, 5'd0};
    #1;
    n_total++;
    if (rd_data[63:32] !== 32'hB) $display("FAIL dual_write_x7: got %h expected 0000000b", rd_data[63:32]);
    else n_pass++;
    wr_en = 2'b01; wr_addr = {5'd0, 5'd0}; wr_data = {32'd0, 32'hFFFFFFFF};
    rd_en = 2'b01; rd_addr = {5'd0, 5'd0};
    #1;
    n_total++;
    if ({rd_data[31:0], rd_busy[0]} !== 33'd0)
      $display("FAIL x0_same_cycle: got data=%h busy=%b expected 0/0", rd_data[31:0], rd_busy[0]);
    else n_pass++;
    tick();
    wr_en = 2'b00;
    #1;
    n_total++;
    if (rd_data[31:0] !== 32'd0) $display("FAIL x0_hardwired: got %h expected 0", rd_data[31:0]);
    else n_pass++;
  endtask

  task automatic test_same_cycle_and_flush();
    idle();
    wr_en = 2'b01; wr_addr = {5'd0, 5'd4}; wr_data = {32'd0, 32'h44};
    iss_valid = 1; iss_addr = 5'd4;
    tick();
    idle();
    rd_en = 2'b01; rd_addr = {5'd0, 5'd4};
    #1;
    n_total++;
    if ({rd_data[31:0], rd_busy[0], rd_stall} !== {32'h44, 2'b11})
      $display("FAIL write_issue_tie: got data=%h busy=%b stall=%b expected 44/1/1", rd_data[31:0], rd_busy[0], rd_stall);
    else n_pass++;
    idle();
    flush = 1; iss_valid = 1; iss_addr = 5'd9;
    tick();
    idle();
    rd_en = 2'b11; rd_addr = {5'd4, 5'd9};
    #1;
    n_total++;
    if ({rd_busy, rd_stall, rd_data[63:32]} !== {3'b000, 32'h44})
      $display("FAIL flush_over_issue: got busy=%b stall=%b x4=%h expected 00/0/44", rd_busy, rd_stall, rd_data[63:32]);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    idle();
    wr_en = 2'b01; wr_addr = {5'd0, 5'd2}; wr_data = {32'd0, 32'h1234};
    tick();
    idle();
    iss_valid = 1; iss_addr = 5'd2;
    tick();
    idle();
    rd_en = 2'b01; rd_addr = {5'd0, 5'd2};
    #1;
    n_total++;
    if ({rd_data[31:0], rd_busy[0]} !== {32'h1234, 1'b1})
      $display("FAIL pre_reset_x2: got data=%h busy=%b expected 1234/1", rd_data[31:0], rd_busy[0]);
    else n_pass++;
    rst = 1'b0;
    #1;
    n_total++;
    if ({init_done, rd_busy, rd_stall, rd_data} !== {4'b0001, 64'd0})
      $display("FAIL mid_reset: got done=%b busy=%b stall=%b data=%h expected 0/00/1/0", init_done, rd_busy, rd_stall, rd_data);
    else n_pass++;
    tick();
    rst = 1'b1;
    wait_init("resweep_time");
    #1;
    n_total++;
    if ({rd_data[31:0], rd_busy[0], rd_stall} !== 34'd0)
      $display("FAIL post_sweep_x2: got data=%h busy=%b stall=%b expected 0/0/0", rd_data[31:0], rd_busy[0], rd_stall);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] d0, d1;
    logic        b0, b1, st;
    for (int c = 0; c < 400; c++) begin
      flush     = ($urandom_range(0, 15) == 0);
      iss_valid = ($urandom_range(0, 2) == 0);
      iss_addr  = 5'($urandom_range(0, 7));
      wr_en     = 2'($urandom);
      wr_addr   = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      wr_data   = {$urandom, $urandom};
      rd_en     = 2'($urandom);
      rd_addr   = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      #1;
      exp_read(0, d0, b0);
      exp_read(1, d1, b1);
      st = !m_run || b0 || b1;
      n_total++;
      if ({rd_data, rd_busy, rd_stall, init_done} !== {d1, d0, b1, b0, st, m_run})
        $display("FAIL random_c%0d: got data=%h busy=%b stall=%b done=%b expected data=%h%h busy=%b%b stall=%b done=%b",
                 c, rd_data, rd_busy, rd_stall, init_done, d1, d0, b1, b0, st, m_run);
      else n_pass++;
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_init_ignore();
    test_issue_hazard();
    test_dual_write();
    test_same_cycle_and_flush();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
